// File: rtl/fpdiv.sv
// Iterative floating-point divider: restoring radix-2 mantissa divide, one quotient
// bit per cycle, then normalize and round to nearest-even with denormal/inf/NaN handling.
//
// state  | meaning
// IDLE   | waiting for start after reset, ready=1
// DIVIDE | one quotient bit per cycle for MAN_BIT+3 cycles
// ROUND  | normalize, denormalize, round, register out
// DONE   | result valid on out, ready=1, new start accepted
module fpdiv #(
    parameter int LOG_BIT = 5,
    parameter int EXP_BIT = 8,
    parameter int N_BIT   = 1 << LOG_BIT,
    parameter int MAN_BIT = N_BIT - EXP_BIT - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    output logic [N_BIT-1:0] out,
    output logic             ready
);

    localparam int Q       = MAN_BIT + 3;
    localparam int EB2     = EXP_BIT + 2;
    localparam int BIAS    = (1 << (EXP_BIT - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_BIT) - 1;
    localparam int CW      = $clog2(Q);

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [Q-1:0]            rem_q, rem_d;
    logic [Q-1:0]            quo_q, quo_d;
    logic [MAN_BIT:0]        mb_q;
    logic signed [EB2-1:0]   e_q;
    logic                    sign_q;
    logic [N_BIT-1:0]        out_q, out_d;
    logic                    ready_q;

    function automatic int lzc(input logic [MAN_BIT:0] v);
        int   n;
        logic found;
        n     = 0;
        found = 1'b0;
        for (int i = MAN_BIT; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 1;
            end
        end
        return n;
    endfunction

    logic                  sign_a, sign_b, sign_r;
    logic [EXP_BIT-1:0]    ex_a, ex_b;
    logic [MAN_BIT-1:0]    mf_a, mf_b;
    logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sign_a = a[N_BIT-1];
    assign sign_b = b[N_BIT-1];
    assign ex_a   = a[N_BIT-2:MAN_BIT];
    assign ex_b   = b[N_BIT-2:MAN_BIT];
    assign mf_a   = a[MAN_BIT-1:0];
    assign mf_b   = b[MAN_BIT-1:0];
    assign sign_r = sign_a ^ sign_b;
    assign nan_a  = (&ex_a) & (|mf_a);
    assign nan_b  = (&ex_b) & (|mf_b);
    assign inf_a  = (&ex_a) & ~(|mf_a);
    assign inf_b  = (&ex_b) & ~(|mf_b);
    assign zero_a = ~(|ex_a) & ~(|mf_a);
    assign zero_b = ~(|ex_b) & ~(|mf_b);

    logic             special_hit;
    logic [N_BIT-1:0] special_word;

    always_comb begin
        special_hit  = 1'b1;
        special_word = '0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            special_word = {sign_r, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};
        end else if (inf_a || zero_b) begin
            special_word = {sign_r, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
        end else if (zero_a || inf_b) begin
            special_word = {sign_r, {(N_BIT-1){1'b0}}};
        end else begin
            special_hit = 1'b0;
        end
    end

    // Denormal operands are shifted up so the divider always sees a hidden 1.
    int                    lz_a, lz_b;
    logic [MAN_BIT:0]      ma_n, mb_n;
    logic signed [EB2-1:0] ea_n, eb_n, e_load;

    always_comb begin
        lz_a = lzc({1'b0, mf_a});
        lz_b = lzc({1'b0, mf_b});
        if (ex_a == '0) begin
            ma_n = {1'b0, mf_a} << lz_a;
            ea_n = EB2'(1 - lz_a);
        end else begin
            ma_n = {1'b1, mf_a};
            ea_n = EB2'(int'(ex_a));
        end
        if (ex_b == '0) begin
            mb_n = {1'b0, mf_b} << lz_b;
            eb_n = EB2'(1 - lz_b);
        end else begin
            mb_n = {1'b1, mf_b};
            eb_n = EB2'(int'(ex_b));
        end
        e_load = ea_n - eb_n + EB2'(BIAS);
    end

    logic [Q-1:0] mb_ext;
    logic         ge;

    always_comb begin
        mb_ext = {2'b00, mb_q};
        ge     = (rem_q >= mb_ext);
        rem_d  = (ge ? (rem_q - mb_ext) : rem_q) << 1;
        quo_d  = {quo_q[Q-2:0], ge};
    end

    logic [Q-1:0]          q_n;
    logic signed [EB2-1:0] e_n;
    int                    sh;
    logic                  st, guard, rup;
    logic [MAN_BIT:0]      m;
    logic [MAN_BIT+1:0]    mr;

    always_comb begin
        q_n = quo_q;
        e_n = e_q;
        sh  = 0;
        st  = |rem_q;
        if (!q_n[Q-1]) begin
            q_n = q_n << 1;
            e_n = e_n - EB2'(1);
        end
        // Results below the normal range are shifted into denormal position.
        if (e_n <= 0) begin
            sh = 1 - int'(e_n);
            if (sh >= Q) begin
                st  = st | (|q_n);
                q_n = '0;
            end else begin
                st  = st | (|(q_n & ~({Q{1'b1}} << sh)));
                q_n = q_n >> sh;
            end
            e_n = '0;
        end
        st    = st | q_n[0];
        guard = q_n[1];
        m     = q_n[Q-1:2];
        rup   = guard & (st | m[0]);
        mr    = {1'b0, m} + {{(MAN_BIT+1){1'b0}}, rup};
        if (mr[MAN_BIT+1]) begin
            mr  = mr >> 1;
            e_n = e_n + EB2'(1);
        end else if (e_n == 0 && mr[MAN_BIT]) begin
            e_n = EB2'(1);
        end
        if (int'(e_n) >= EXP_MAX) begin
            out_d = {sign_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
        end else begin
            out_d = {sign_q, e_n[EXP_BIT-1:0], mr[MAN_BIT-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            mb_q    <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            out_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sign_q <= sign_r;
                        if (special_hit) begin
                            out_q   <= special_word;
                            state_q <= DONE;
                        end else begin
                            rem_q   <= {2'b00, ma_n};
                            mb_q    <= mb_n;
                            quo_q   <= '0;
                            e_q     <= e_load;
                            cnt_q   <= CW'(Q - 1);
                            ready_q <= 1'b0;
                            state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) state_q <= ROUND;
                end
                ROUND: begin
                    out_q   <= out_d;
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_fpdiv.sv
// Directed bench for fpdiv (binary32): results, latency, specials, range edges, control.
module tb_fpdiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] out;
    logic        ready;
    int          checks = 0;
    int          errors = 0;
    int          n;

    fpdiv dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .out  (out),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Returns after the result is visible; lat = edges after the accepting edge.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [31:0] texp, input int tlat, input int poke);
        int k;
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!ready && k < 100) begin
            if (k + 1 == poke) begin
                a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
            end
            @(negedge clk);
            k++;
            start = 1'b0;
        end
        chk({tag, " latency"}, 32'(k), 32'(tlat));
        chk({tag, " out"}, out, texp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset out", out, 32'h0);
        rst = 1'b0;

        run_op("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 27, -1);
        run_op("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 27, -1);
        run_op("1/1.5", 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 27, -1);

        run_op("x/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 0, -1);
        run_op("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 0, -1);
        run_op("-1/inf", 32'hBF800000, 32'h7F800000, 32'h80000000, 0, -1);
        run_op("nan/1", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, -1);

        run_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 27, -1);
        run_op("underflow", 32'h00800000, 32'h40000000, 32'h00400000, 27, -1);
        run_op("denorm in", 32'h00000001, 32'h3F000000, 32'h00000002, 27, -1);
        run_op("full uflow", 32'h00000001, 32'h7F000000, 32'h00000000, 27, -1);

        run_op("busy start", 32'h40C00000, 32'h40000000, 32'h40400000, 27, 5);

        // Reset at edge 10 of a busy operation.
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid ready", 32'(ready), 32'd1);
        chk("rst mid out", out, 32'h0);
        start = 1'b1;
        @(negedge clk);
        chk("rst+start ready", 32'(ready), 32'd1);
        chk("rst+start out", out, 32'h0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst+start not accepted", 32'(ready), 32'd1);

        // start held high through DONE re-accepts with no bubble.
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first latency", 32'(n), 32'd27);
        chk("b2b first out", out, 32'h40400000);
        a = 32'h3F800000; b = 32'h40400000;
        @(negedge clk);
        n++;
        chk("b2b second accepted", 32'(ready), 32'd0);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("b2b second edge", 32'(n), 32'd55);
        chk("b2b second out", out, 32'h3EAAAAAB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
